// File: rtl/dynamatic_handshake_pkg.sv
// Shared handshake helpers: width functions and the reset polarity constant.
// Used by the elastic FIFO top level and its storage array.
package dynamatic_handshake_pkg;

    localparam logic HS_RESET_ACTIVE = 1'b0;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

    // Pointer width never drops below one bit, so DEPTH==1 still has a legal index.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth <= 1) ? 1 : clog2(depth);
    endfunction

    function automatic int unsigned occ_width(input int unsigned depth);
        return clog2(depth + 1);
    endfunction

    function automatic int unsigned data_width(input int unsigned dw);
        return (dw == 0) ? 1 : dw;
    endfunction

endpackage

// File: rtl/elastic_fifo_mem.sv
// DEPTH x WIDTH register array with one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module elastic_fifo_mem
    import dynamatic_handshake_pkg::*;
#(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 2
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [ptr_width(Depth)-1:0]  wr_ptr,
    input  logic [Width-1:0]             wr_data,
    input  logic [ptr_width(Depth)-1:0]  rd_ptr,
    output logic [Width-1:0]             rd_data
);

    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr];

endmodule

// File: rtl/elastic_fifo_buffer.sv
// Depth-parameterised elastic FIFO for one valid/ready channel.
// Optional feature: define ELASTIC_FIFO_BYPASS_EN for a zero-latency path when empty.
module elastic_fifo_buffer
    import dynamatic_handshake_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [data_width(DATA_WIDTH)-1:0]  ins,
    input  logic                               ins_valid,
    output logic                               ins_ready,
    output logic [data_width(DATA_WIDTH)-1:0]  outs,
    output logic                               outs_valid,
    input  logic                               outs_ready,
    output logic [occ_width(DEPTH)-1:0]        occupancy
);

    localparam int unsigned DataW = data_width(DATA_WIDTH);
    localparam int unsigned PtrW  = ptr_width(DEPTH);
    localparam int unsigned OccW  = occ_width(DEPTH);

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OccW-1:0]  occ_q, occ_d;
    logic             empty, full, push, pop, bypass_fire;
    logic [DataW-1:0] head_data;

    always_comb begin
        empty     = (occ_q == '0);
        full      = (occ_q == OccW'(DEPTH));
        // Ready depends on stored state only; a pop while full does not open a slot.
        ins_ready = ~full;
`ifdef ELASTIC_FIFO_BYPASS_EN
        outs_valid  = ~empty | ins_valid;
        outs        = empty ? ins : head_data;
        bypass_fire = empty & ins_valid & outs_ready;
`else
        outs_valid  = ~empty;
        outs        = head_data;
        bypass_fire = 1'b0;
`endif
        push = ins_valid & ~full & ~bypass_fire;
        pop  = ~empty & outs_ready;

        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == HS_RESET_ACTIVE) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign occupancy = occ_q;

    elastic_fifo_mem #(
        .Width(DataW),
        .Depth(DEPTH)
    ) u_mem (
        .clk    (clk),
        .wr_en  (push),
        .wr_ptr (wr_ptr_q),
        .wr_data(ins),
        .rd_ptr (rd_ptr_q),
        .rd_data(head_data)
    );

endmodule

// File: tb/tb_elastic_fifo_buffer.sv
// Directed-vector and randomised scoreboard bench for elastic_fifo_buffer at
// DEPTH 1, 2, 5 and 3; expectations follow ELASTIC_FIFO_BYPASS_EN when defined.
module tb_elastic_fifo_buffer;

`ifdef ELASTIC_FIFO_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       iv  [N];
    logic       orr [N];
    logic [7:0] id  [N];
    logic       ov  [N];
    logic       ir  [N];
    logic [7:0] od  [N];
    logic [2:0] occ [N];
    logic [0:0] occ0;
    logic [1:0] occ1;
    logic [2:0] occ2;
    logic [1:0] occ3;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    assign occ[0] = {2'b00, occ0};
    assign occ[1] = {1'b0, occ1};
    assign occ[2] = occ2;
    assign occ[3] = {1'b0, occ3};

    elastic_fifo_buffer #(.DATA_WIDTH(8), .DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst), .ins(id[0]), .ins_valid(iv[0]), .ins_ready(ir[0]),
        .outs(od[0]), .outs_valid(ov[0]), .outs_ready(orr[0]), .occupancy(occ0)
    );
    elastic_fifo_buffer #(.DATA_WIDTH(8), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .ins(id[1]), .ins_valid(iv[1]), .ins_ready(ir[1]),
        .outs(od[1]), .outs_valid(ov[1]), .outs_ready(orr[1]), .occupancy(occ1)
    );
    elastic_fifo_buffer #(.DATA_WIDTH(8), .DEPTH(5)) u_d5 (
        .clk(clk), .rst(rst), .ins(id[2]), .ins_valid(iv[2]), .ins_ready(ir[2]),
        .outs(od[2]), .outs_valid(ov[2]), .outs_ready(orr[2]), .occupancy(occ2)
    );
    elastic_fifo_buffer #(.DATA_WIDTH(8), .DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst), .ins(id[3]), .ins_valid(iv[3]), .ins_ready(ir[3]),
        .outs(od[3]), .outs_valid(ov[3]), .outs_ready(orr[3]), .occupancy(occ3)
    );

    function automatic int dep(input int k);
        case (k)
            0:       return 1;
            1:       return 2;
            2:       return 5;
            default: return 3;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       orr;
        logic       eir;
        logic       eov;
        logic       cd;
        logic [7:0] eo;
        logic [2:0] eocc;
    } vec_t;

    vec_t tv [7];

    // Reference model: circular buffer per instance.
    logic [7:0] mb [N][8];
    int mh [N];
    int mc [N];

    initial begin
        tv[0] = '{1'b1, 8'hA1, 1'b0, 1'b1, Byp,  Byp,  8'hA1, 3'd0};
        tv[1] = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA1, 3'd1};
        tv[2] = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1, 3'd2};
        tv[3] = '{1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA1, 3'd2};
        tv[4] = '{1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA2, 3'd1};
        tv[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA3, 3'd1};
        tv[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0};

        rst = 1'b0;
        for (int k = 0; k < N; k++) begin
            iv[k] = 1'b0; orr[k] = 1'b0; id[k] = 8'h00;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check($sformatf("reset_occ_d%0d", dep(k)), 32'(occ[k]), 32'd0);
            check($sformatf("reset_outs_valid_d%0d", dep(k)), 32'(ov[k]), 32'd0);
            check($sformatf("reset_ins_ready_d%0d", dep(k)), 32'(ir[k]), 32'd1);
        end
        next_cycle();

        // Fill DEPTH=2, stall, then drain in order.
        for (int i = 0; i < 7; i++) begin
            iv[1] = tv[i].iv; id[1] = tv[i].d; orr[1] = tv[i].orr;
            @(negedge clk);
            check($sformatf("vec%0d_ins_ready", i), 32'(ir[1]), 32'(tv[i].eir));
            check($sformatf("vec%0d_outs_valid", i), 32'(ov[1]), 32'(tv[i].eov));
            check($sformatf("vec%0d_occupancy", i), 32'(occ[1]), 32'(tv[i].eocc));
            if (tv[i].cd) check($sformatf("vec%0d_outs", i), 32'(od[1]), 32'(tv[i].eo));
            next_cycle();
        end

        // DEPTH=3 streaming across pointer wrap with one token resident.
        iv[3] = 1'b1; id[3] = 8'h10; orr[3] = 1'b0;
        next_cycle();
        for (int k = 0; k < 10; k++) begin
            iv[3] = 1'b1; id[3] = 8'(8'h11 + k); orr[3] = 1'b1;
            @(negedge clk);
            check($sformatf("stream%0d_outs", k), 32'(od[3]), 32'(8'h10 + k));
            check($sformatf("stream%0d_occ", k), 32'(occ[3]), 32'd1);
            next_cycle();
        end
        iv[3] = 1'b0;
        @(negedge clk);
        check("stream_last_outs", 32'(od[3]), 32'h1A);
        next_cycle();
        orr[3] = 1'b0;
        @(negedge clk);
        check("stream_drained_occ", 32'(occ[3]), 32'd0);
        next_cycle();

        // Reset while DEPTH=2 holds two tokens.
        iv[1] = 1'b1; id[1] = 8'hB1; orr[1] = 1'b0;
        next_cycle();
        id[1] = 8'hB2;
        next_cycle();
        iv[1] = 1'b0;
        @(negedge clk);
        check("pre_rst_occ", 32'(occ[1]), 32'd2);
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_occ", 32'(occ[1]), 32'd0);
        check("post_rst_outs_valid", 32'(ov[1]), 32'd0);
        check("post_rst_ins_ready", 32'(ir[1]), 32'd1);
        iv[1] = 1'b1; id[1] = 8'hC1;
        next_cycle();
        iv[1] = 1'b0;
        @(negedge clk);
        check("post_rst_new_head", 32'(od[1]), 32'hC1);
        check("post_rst_new_occ", 32'(occ[1]), 32'd1);
        orr[1] = 1'b1;
        next_cycle();
        orr[1] = 1'b0;
        @(negedge clk);
        check("post_rst_drained", 32'(ov[1]), 32'd0);
        next_cycle();

        // Empty FIFO with a token offered and consumer ready.
        iv[1] = 1'b1; id[1] = 8'h05; orr[1] = 1'b1;
        @(negedge clk);
        check("empty_offer_outs_valid", 32'(ov[1]), 32'(Byp));
        check("empty_offer_occ", 32'(occ[1]), 32'd0);
        if (Byp) check("bypass_outs", 32'(od[1]), 32'h05);
        next_cycle();
        iv[1] = 1'b0; orr[1] = 1'b0;
        @(negedge clk);
        check("after_offer_occ", 32'(occ[1]), Byp ? 32'd0 : 32'd1);
        check("after_offer_outs_valid", 32'(ov[1]), Byp ? 32'd0 : 32'd1);
        if (!Byp) check("after_offer_outs", 32'(od[1]), 32'h05);
        orr[1] = 1'b1;
        next_cycle();
        orr[1] = 1'b0;
        next_cycle();

        // Random traffic against the model on all instances at once.
        for (int k = 0; k < N; k++) begin
            mh[k] = 0; mc[k] = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < N; k++) begin
                iv[k]  = ($urandom_range(0, 3) != 0);
                orr[k] = ($urandom_range(0, 2) != 0);
                id[k]  = 8'($urandom);
            end
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                logic       e_ir, e_ov, pass, push, pop;
                logic [7:0] e_od;
                e_ir = (mc[k] != dep(k));
                e_ov = (mc[k] != 0) || (Byp && iv[k]);
                e_od = (mc[k] != 0) ? mb[k][mh[k]] : id[k];
                check($sformatf("rand_d%0d_cyc%0d", dep(k), c),
                      {19'd0, ir[k], ov[k], occ[k], e_ov ? od[k] : 8'h00},
                      {19'd0, e_ir, e_ov, 3'(mc[k]), e_ov ? e_od : 8'h00});
                pass = Byp && (mc[k] == 0) && iv[k] && orr[k];
                push = iv[k] && e_ir && !pass;
                pop  = (mc[k] != 0) && orr[k];
                if (pop) begin
                    mh[k] = (mh[k] + 1) % dep(k);
                    mc[k]--;
                end
                if (push) begin
                    mb[k][(mh[k] + mc[k]) % dep(k)] = id[k];
                    mc[k]++;
                end
            end
            next_cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
